mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 200 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter sharing one memory between the core requester
// (port 0) and a secondary bus master (port 1). Each accepted command is
// registered, driven to memory for MEM_LATENCY cycles, and answered with a
// one-cycle done pulse on the granted port.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking;
// otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int unsigned MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req0_valid,
    input  logic        req0_is_write,
    input  logic        req0_is_unsigned,
    input  logic [1:0]  req0_op_size,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_accept,
    output logic        req0_done,
    output logic [31:0] req0_rdata,
    output logic [2:0]  req0_fault_num,

    input  logic        req1_valid,
    input  logic        req1_is_write,
    input  logic        req1_is_unsigned,
    input  logic [1:0]  req1_op_size,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_accept,
    output logic        req1_done,
    output logic [31:0] req1_rdata,
    output logic [2:0]  req1_fault_num,

    output logic        mem_enable_n,
    output logic        mem_is_write,
    output logic        mem_is_unsigned,
    output logic [1:0]  mem_op_size,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_in,
    input  logic [31:0] mem_out,
    input  logic [2:0]  mem_fault_num,

    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state, state_next;
    logic [3:0]  cnt;
    logic        any_valid;
    logic        grant_sel;   // winner in the current IDLE cycle (1 = port 1)
    logic        grant;       // port owning the in-flight command
    logic        take;        // command accepted this cycle

    logic        cmd_is_write;
    logic        cmd_is_unsigned;
    logic [1:0]  cmd_op_size;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [31:0] resp_data;
    logic [2:0]  resp_fault;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic        last_grant;
`endif

    // Winner selection: a lone requester wins; ties go to priority or round-robin.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        grant_sel = ~req0_valid;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_grant;
        end
`endif
    end

    // Next-state logic and accept strobes.
    always_comb begin
        state_next  = state;
        take        = 1'b0;
        req0_accept = 1'b0;
        req1_accept = 1'b0;
        case (state)
            IDLE: begin
                if (any_valid && !reset) begin
                    take        = 1'b1;
                    req0_accept = ~grant_sel;
                    req1_accept = grant_sel;
                    state_next  = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Command/response registers, latency counter and grant tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt             <= '0;
            grant           <= 1'b0;
            cmd_is_write    <= 1'b0;
            cmd_is_unsigned <= 1'b0;
            cmd_op_size     <= '0;
            cmd_addr        <= '0;
            cmd_wdata       <= '0;
            resp_data       <= '0;
            resp_fault      <= '0;
        end else begin
            if (take) begin
                cnt             <= 4'(MEM_LATENCY - 1);
                grant           <= grant_sel;
                cmd_is_write    <= grant_sel ? req1_is_write    : req0_is_write;
                cmd_is_unsigned <= grant_sel ? req1_is_unsigned : req0_is_unsigned;
                cmd_op_size     <= grant_sel ? req1_op_size     : req0_op_size;
                cmd_addr        <= grant_sel ? req1_addr        : req0_addr;
                cmd_wdata       <= grant_sel ? req1_wdata       : req0_wdata;
            end else if (state == ACCESS) begin
                if (cnt != 4'd0) begin
                    cnt <= cnt - 4'd1;
                end else begin
                    resp_data  <= mem_out;
                    resp_fault <= mem_fault_num;
                end
            end
        end
    end

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Round-robin pointer: starts at 1 so port 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (take) begin
            last_grant <= grant_sel;
        end
    end
`endif

    // Memory command, response routing and status outputs.
    always_comb begin
        mem_enable_n    = 1'b1;
        mem_is_write    = 1'b0;
        mem_is_unsigned = 1'b0;
        mem_op_size     = '0;
        mem_addr        = '0;
        mem_in          = '0;
        req0_done       = 1'b0;
        req1_done       = 1'b0;
        req0_rdata      = '0;
        req1_rdata      = '0;
        req0_fault_num  = '0;
        req1_fault_num  = '0;
        busy            = (state != IDLE);
        if (state == ACCESS) begin
            mem_enable_n    = 1'b0;
            mem_is_write    = cmd_is_write;
            mem_is_unsigned = cmd_is_unsigned;
            mem_op_size     = cmd_op_size;
            mem_addr        = cmd_addr;
            mem_in          = cmd_wdata;
        end
        if (state == RESP) begin
            if (grant) begin
                req1_done      = 1'b1;
                req1_rdata     = resp_data;
                req1_fault_num = resp_fault;
            end else begin
                req0_done      = 1'b1;
                req0_rdata     = resp_data;
                req0_fault_num = resp_fault;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LATENCY=1 (a_*) and one
// at MEM_LATENCY=3 (b_*), sharing the same requester and memory stimulus.
module tb_mem_arbiter;

    logic        clk;
    logic        reset;
    logic        req0_valid, req0_is_write, req0_is_unsigned;
    logic [1:0]  req0_op_size;
    logic [31:0] req0_addr, req0_wdata;
    logic        req1_valid, req1_is_write, req1_is_unsigned;
    logic [1:0]  req1_op_size;
    logic [31:0] req1_addr, req1_wdata;
    logic [31:0] mem_out;
    logic [2:0]  mem_fault_num;

    logic        a_acc0, a_acc1, a_done0, a_done1, a_en_n, a_wr, a_uns, a_busy;
    logic [31:0] a_rd0, a_rd1, a_addr, a_in;
    logic [2:0]  a_f0, a_f1;
    logic [1:0]  a_sz;
    logic        b_acc0, b_acc1, b_done0, b_done1, b_en_n, b_wr, b_uns, b_busy;
    logic [31:0] b_rd0, b_rd1, b_addr, b_in;
    logic [2:0]  b_f0, b_f1;
    logic [1:0]  b_sz;

    int checks = 0;
    int fails  = 0;

    mem_arbiter #(.MEM_LATENCY(1)) u_a (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_is_write(req0_is_write), .req0_is_unsigned(req0_is_unsigned),
        .req0_op_size(req0_op_size), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_accept(a_acc0), .req0_done(a_done0), .req0_rdata(a_rd0), .req0_fault_num(a_f0),
        .req1_valid(req1_valid), .req1_is_write(req1_is_write), .req1_is_unsigned(req1_is_unsigned),
        .req1_op_size(req1_op_size), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_accept(a_acc1), .req1_done(a_done1), .req1_rdata(a_rd1), .req1_fault_num(a_f1),
        .mem_enable_n(a_en_n), .mem_is_write(a_wr), .mem_is_unsigned(a_uns), .mem_op_size(a_sz),
        .mem_addr(a_addr), .mem_in(a_in), .mem_out(mem_out), .mem_fault_num(mem_fault_num),
        .busy(a_busy)
    );

    mem_arbiter #(.MEM_LATENCY(3)) u_b (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_is_write(req0_is_write), .req0_is_unsigned(req0_is_unsigned),
        .req0_op_size(req0_op_size), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req0_accept(b_acc0), .req0_done(b_done0), .req0_rdata(b_rd0), .req0_fault_num(b_f0),
        .req1_valid(req1_valid), .req1_is_write(req1_is_write), .req1_is_unsigned(req1_is_unsigned),
        .req1_op_size(req1_op_size), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_accept(b_acc1), .req1_done(b_done1), .req1_rdata(b_rd1), .req1_fault_num(b_f1),
        .mem_enable_n(b_en_n), .mem_is_write(b_wr), .mem_is_unsigned(b_uns), .mem_op_size(b_sz),
        .mem_addr(b_addr), .mem_in(b_in), .mem_out(mem_out), .mem_fault_num(mem_fault_num),
        .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs;
        req0_valid = 0; req0_is_write = 0; req0_is_unsigned = 0; req0_op_size = 0;
        req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_is_write = 0; req1_is_unsigned = 0; req1_op_size = 0;
        req1_addr = 0; req1_wdata = 0;
        mem_out = 0; mem_fault_num = 0;
    endtask

    task automatic do_reset;
        clear_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
    endtask

    task automatic test_reset;
        clear_inputs();
        reset = 1;
        req0_valid = 1; req1_valid = 1;
        tick(); tick(); #1;
        checks++;
        if ({a_acc0, a_acc1, b_acc0, b_acc1} !== 4'b0000) begin
            $display("FAIL reset_accept: got %b want 0000", {a_acc0, a_acc1, b_acc0, b_acc1});
            fails++;
        end
        clear_inputs();
        tick();
        reset = 0;
        #1;
        checks++;
        if ({a_en_n, a_wr, a_uns, a_sz, a_addr, a_in, a_busy, a_done0, a_done1, a_rd0, a_rd1, a_f0, a_f1}
            !== {1'b1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'h0, 3'h0}) begin
            $display("FAIL reset_outputs: en_n=%b busy=%b addr=%h done=%b%b", a_en_n, a_busy, a_addr, a_done0, a_done1);
            fails++;
        end
    endtask

    task automatic test_load_lat1;
        do_reset();
        req0_valid = 1; req0_op_size = 2'b10; req0_addr = 32'h100;
        mem_out = 32'hDEADBEEF;
        #1;
        checks++;
        if ({a_acc0, a_acc1, a_en_n} !== 3'b101) begin
            $display("FAIL lat1_accept_T: acc0=%b acc1=%b en_n=%b want 1 0 1", a_acc0, a_acc1, a_en_n);
            fails++;
        end
        tick();
        req0_valid = 0; #1;
        checks++;
        if ({a_en_n, a_busy, a_addr, a_sz, a_wr} !== {1'b0, 1'b1, 32'h100, 2'b10, 1'b0}) begin
            $display("FAIL lat1_access_T1: en_n=%b busy=%b addr=%h sz=%b want 0 1 00000100 10", a_en_n, a_busy, a_addr, a_sz);
            fails++;
        end
        tick();
        checks++;
        if ({a_en_n, a_done0, a_done1, a_rd0, a_rd1, a_addr} !== {1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0}) begin
            $display("FAIL lat1_done_T2: en_n=%b done0=%b done1=%b rdata0=%h rdata1=%h want 1 1 0 deadbeef 0", a_en_n, a_done0, a_done1, a_rd0, a_rd1);
            fails++;
        end
        tick();
        checks++;
        if ({a_busy, a_done0} !== 2'b00) begin
            $display("FAIL lat1_idle_T3: busy=%b done0=%b want 0 0", a_busy, a_done0);
            fails++;
        end
    endtask

    task automatic test_store_lat3;
        do_reset();
        req1_valid = 1; req1_is_write = 1; req1_op_size = 2'b00;
        req1_addr = 32'h2003; req1_wdata = 32'hA5;
        #1;
        checks++;
        if ({b_acc0, b_acc1, b_en_n} !== 3'b011) begin
            $display("FAIL lat3_accept_T: acc0=%b acc1=%b en_n=%b want 0 1 1", b_acc0, b_acc1, b_en_n);
            fails++;
        end
        tick();
        req1_valid = 0; req1_addr = 32'hFFFF; req1_wdata = 32'h0; req1_is_write = 0;
        #1;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if ({b_en_n, b_wr, b_sz, b_addr, b_in, b_done1} !== {1'b0, 1'b1, 2'b00, 32'h2003, 32'hA5, 1'b0}) begin
                $display("FAIL lat3_access_T%0d: en_n=%b wr=%b sz=%b addr=%h in=%h done1=%b want 0 1 00 00002003 000000a5 0",
                         k, b_en_n, b_wr, b_sz, b_addr, b_in, b_done1);
                fails++;
            end
            tick();
        end
        checks++;
        if ({b_en_n, b_wr, b_addr, b_in, b_done1, b_done0, b_busy} !== {1'b1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1}) begin
            $display("FAIL lat3_done_T4: en_n=%b wr=%b addr=%h done1=%b done0=%b busy=%b want 1 0 0 1 0 1",
                     b_en_n, b_wr, b_addr, b_done1, b_done0, b_busy);
            fails++;
        end
        tick();
        checks++;
        if ({b_busy, b_done1} !== 2'b00) begin
            $display("FAIL lat3_idle_T5: busy=%b done1=%b want 0 0", b_busy, b_done1);
            fails++;
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] grants;
        logic [3:0] exp_grants;
        int n;
        bit got1;
        do_reset();
        grants = '0;
        n = 0;
        req0_valid = 1; req0_addr = 32'h10;
        req1_valid = 1; req1_addr = 32'h20;
        #1;
        for (int c = 0; c < 40 && n < 4; c++) begin
            if (a_acc0 || a_acc1) begin
                grants[n] = a_acc1;
                n++;
            end
            tick();
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        exp_grants = 4'b1010;
`else
        exp_grants = 4'b0000;
`endif
        checks++;
        if (n != 4) begin
            $display("FAIL b2b_count: got %0d accepts want 4", n);
            fails++;
        end
        checks++;
        if (grants !== exp_grants) begin
            $display("FAIL b2b_grants: got %b want %b (bit i = port of access i)", grants, exp_grants);
            fails++;
        end
        req0_valid = 0;
        got1 = 0;
        for (int c = 0; c < 10 && !got1; c++) begin
            if (a_acc1) got1 = 1;
            else tick();
        end
        checks++;
        if (got1 !== 1'b1) begin
            $display("FAIL b2b_port1_after_drop: got accept1=%b want 1 within 10 cycles", got1);
            fails++;
        end
        req1_valid = 0;
        tick(); tick(); tick();
    endtask

    task automatic test_fault;
        do_reset();
        req0_valid = 1; req0_op_size = 2'b10; req0_addr = 32'h300;
        mem_out = 32'h12345678; mem_fault_num = 3'd3;
        #1;
        checks++;
        if (a_acc0 !== 1'b1) begin
            $display("FAIL fault_accept: acc0=%b want 1", a_acc0);
            fails++;
        end
        tick();
        req0_valid = 0;
        tick();
        checks++;
        if ({a_done0, a_f0, a_rd0, a_f1} !== {1'b1, 3'd3, 32'h12345678, 3'd0}) begin
            $display("FAIL fault_done: done0=%b fault0=%0d rdata0=%h fault1=%0d want 1 3 12345678 0", a_done0, a_f0, a_rd0, a_f1);
            fails++;
        end
        tick();
        mem_fault_num = 3'd0; mem_out = 32'hCAFE0001;
        req1_valid = 1; req1_addr = 32'h400;
        #1;
        checks++;
        if ({a_busy, a_acc1} !== 2'b01) begin
            $display("FAIL fault_next_accept: busy=%b acc1=%b want 0 1", a_busy, a_acc1);
            fails++;
        end
        tick();
        req1_valid = 0;
        tick();
        checks++;
        if ({a_done1, a_rd1, a_f1, a_done0} !== {1'b1, 32'hCAFE0001, 3'd0, 1'b0}) begin
            $display("FAIL fault_next_done: done1=%b rdata1=%h fault1=%0d done0=%b want 1 cafe0001 0 0", a_done1, a_rd1, a_f1, a_done0);
            fails++;
        end
    endtask

    task automatic test_reset_mid_access;
        bit saw_done;
        do_reset();
        req0_valid = 1; req0_addr = 32'h500;
        #1;
        tick();
        req0_valid = 0;
        tick();
        reset = 1;
        #1;
        saw_done = b_done0 | b_done1;
        tick();
        reset = 0;
        #1;
        checks++;
        if ({b_en_n, b_busy} !== 2'b10) begin
            $display("FAIL rst_mid_after: en_n=%b busy=%b want 1 0", b_en_n, b_busy);
            fails++;
        end
        for (int c = 0; c < 6; c++) begin
            saw_done = saw_done | b_done0 | b_done1;
            tick();
        end
        checks++;
        if (saw_done !== 1'b0) begin
            $display("FAIL rst_mid_no_done: done seen=%b want 0", saw_done);
            fails++;
        end
        req0_valid = 1; req1_valid = 1;
        #1;
        checks++;
        if ({b_acc0, b_acc1} !== 2'b10) begin
            $display("FAIL rst_mid_tie: acc0=%b acc1=%b want 1 0", b_acc0, b_acc1);
            fails++;
        end
        clear_inputs();
    endtask

    task automatic test_addr_hold;
        do_reset();
        req0_valid = 1; req0_addr = 32'h100; req0_op_size = 2'b10;
        #1;
        tick();
        req0_valid = 0; req0_addr = 32'h200;
        #1;
        for (int k = 1; k <= 3; k++) begin
            checks++;
            if ({b_en_n, b_addr} !== {1'b0, 32'h100}) begin
                $display("FAIL addr_hold_T%0d: en_n=%b addr=%h want 0 00000100", k, b_en_n, b_addr);
                fails++;
            end
            tick();
        end
        tick(); tick();
    endtask

    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_load_lat1();
        test_store_lat3();
        test_back_to_back();
        test_fault();
        test_reset_mid_access();
        test_addr_hold();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

endmodule
